// File: rtl/v_logical_right_shifter_seq_pkg.sv
// Shared types and constants for the iterative right shifter.
// Holds the FSM state encoding and the default operand width.
// No logic; imported by v_logical_right_shifter_seq.
package v_logical_right_shifter_seq_pkg;

  // FSM encoding: RDY decodes from IDLE, VLD decodes from DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } lrs_state_t;

  // Default data width of the shifter.
  localparam int LRS_WIDTH = 8;

endpackage

// File: rtl/v_logical_right_shifter_seq.sv
// Iterative right shifter: one bit per clock, result held until acknowledged.
// Latency: SEL+1 edges including the accept edge (SEL=0 is valid after the accept edge).
// Backpressure: the result and VLD are held while ACK=0; LOAD is ignored unless RDY=1.
// Optional macro LRS_ARITH_EN adds the ARITH port (fill with the captured sign bit).
module v_logical_right_shifter_seq
  import v_logical_right_shifter_seq_pkg::*;
#(
  parameter int WIDTH = LRS_WIDTH,
  parameter int SW    = 3
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] DI,
  input  logic [SW-1:0]    SEL,
  input  logic             LOAD,
`ifdef LRS_ARITH_EN
  input  logic             ARITH,
`endif
  input  logic             ACK,
  output logic             RDY,
  output logic [WIDTH-1:0] SO,
  output logic             VLD
);

  lrs_state_t       state_q;
  lrs_state_t       state_d;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    cnt_q;
  logic             fill;

`ifdef LRS_ARITH_EN
  logic fill_q;

  // Capture the fill bit with the operand so later ARITH/DI changes cannot disturb it.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      fill_q <= 1'b0;
    end else if (state_q == IDLE && LOAD) begin
      fill_q <= ARITH & DI[WIDTH-1];
    end
  end

  assign fill = fill_q;
`else
  assign fill = 1'b0;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: zero-distance requests skip straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (LOAD) begin
          state_d = (SEL == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ACK) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one-bit shift and count-down while in SHIFT, hold otherwise.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (LOAD) begin
            data_q <= DI;
            cnt_q  <= SEL;
          end
        end
        SHIFT: begin
          data_q <= {fill, data_q[WIDTH-1:1]};
          cnt_q  <= cnt_q - SW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign RDY = (state_q == IDLE);
  assign VLD = (state_q == DONE);
  assign SO  = data_q;

endmodule

// File: tb/tb_v_logical_right_shifter_seq.sv
// Self-checking bench for v_logical_right_shifter_seq (WIDTH=8, SW=3).
// A transaction-level model predicts RDY/VLD/SO every cycle; directed tasks pin literals.
// Build with LRS_ARITH_EN defined to also exercise the arithmetic fill.
module tb_v_logical_right_shifter_seq;

  logic       C;
  logic       CLR_N;
  logic [7:0] DI;
  logic [2:0] SEL;
  logic       LOAD;
  logic       ACK;
  logic       arith;
  logic       RDY;
  logic [7:0] SO;
  logic       VLD;

  int checks = 0;
  int errors = 0;

  v_logical_right_shifter_seq #(.WIDTH(8), .SW(3)) dut (
    .C     (C),
    .CLR_N (CLR_N),
    .DI    (DI),
    .SEL   (SEL),
    .LOAD  (LOAD),
`ifdef LRS_ARITH_EN
    .ARITH (arith),
`endif
    .ACK   (ACK),
    .RDY   (RDY),
    .SO    (SO),
    .VLD   (VLD)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected result of one request, straight from the arithmetic meaning of the shift.
  function automatic logic [7:0] shift_model(input logic [7:0] d, input logic [2:0] s,
                                             input logic ar);
    logic use_arith;
`ifdef LRS_ARITH_EN
    use_arith = ar;
`else
    use_arith = 1'b0;
    if (ar) use_arith = 1'b0;
`endif
    if (use_arith) return 8'($signed(d) >>> s);
    return d >> s;
  endfunction

  // Transaction model: a request accepted at edge e is valid after edge e+SEL and
  // stays valid until an ACK edge; SO then holds the delivered value.
  bit         m_busy  = 1'b0;
  int         m_ready = 0;
  int         cyc     = 0;
  logic [7:0] m_res   = 8'h00;
  logic [7:0] m_so    = 8'h00;

  function automatic bit m_vld();
    return m_busy && (cyc > m_ready);
  endfunction

  always @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      m_busy = 1'b0;
      m_so   = 8'h00;
      cyc    = 0;
    end else begin
      if (!m_busy) begin
        if (LOAD) begin
          m_busy  = 1'b1;
          m_ready = cyc + int'(SEL);
          m_res   = shift_model(DI, SEL, arith);
        end
      end else if (m_vld() && ACK) begin
        m_busy = 1'b0;
        m_so   = m_res;
      end
      cyc++;
    end
  end

  // Cycle compare against the model; SO is only meaningful when idle or valid.
  always @(posedge C) begin
    #2;
    chk("cmp rdy", 32'(RDY), 32'(!m_busy));
    chk("cmp vld", 32'(VLD), 32'(m_vld()));
    if (m_vld())      chk("cmp so_vld",  32'(SO), 32'(m_res));
    else if (!m_busy) chk("cmp so_idle", 32'(SO), 32'(m_so));
  end

  // One request with ACK tied high; inputs are scrambled right after the accept edge.
  task automatic run(input string nm, input logic [7:0] d, input logic [2:0] s,
                     input logic ar, input logic [7:0] exp_so, input int exp_lat);
    int n;
    DI = d; SEL = s; arith = ar; LOAD = 1'b1; ACK = 1'b1;
    @(posedge C); #1;
    LOAD = 1'b0; DI = ~d; SEL = ~s; arith = ~ar;
    n = 1;
    while (!VLD && n < 40) begin
      @(posedge C); #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    chk({nm, " so"}, 32'(SO), 32'(exp_so));
    @(posedge C); #1;
    chk({nm, " rdy_after_ack"}, 32'(RDY), 32'd1);
    chk({nm, " vld_after_ack"}, 32'(VLD), 32'd0);
    arith = 1'b0;
  endtask

  initial begin
    CLR_N = 1'b0; DI = 8'h00; SEL = 3'd0; LOAD = 1'b0; ACK = 1'b0; arith = 1'b0;
    #23;
    chk("reset rdy", 32'(RDY), 32'd1);
    chk("reset vld", 32'(VLD), 32'd0);
    chk("reset so",  32'(SO),  32'h00);
    @(posedge C); #1;
    CLR_N = 1'b1;
    @(posedge C); #1;

    run("basic",   8'hB4, 3'd2, 1'b0, 8'h2D, 3);
    run("zero",    8'h5A, 3'd0, 1'b0, 8'h5A, 1);
    run("max80",   8'h80, 3'd7, 1'b0, 8'h01, 8);
    run("maxFF",   8'hFF, 3'd7, 1'b0, 8'h01, 8);
    run("one",     8'h81, 3'd1, 1'b0, 8'h40, 2);

    // Backpressure: hold the result, ignore a LOAD pulse during the stall.
    DI = 8'h3C; SEL = 3'd1; LOAD = 1'b1; ACK = 1'b0;
    @(posedge C); #1;
    LOAD = 1'b0;
    @(posedge C); #1;
    chk("bp vld_rise", 32'(VLD), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        DI = 8'hAA; SEL = 3'd0; LOAD = 1'b1;
      end
      @(posedge C); #1;
      LOAD = 1'b0;
      chk("bp vld_hold", 32'(VLD), 32'd1);
      chk("bp rdy_hold", 32'(RDY), 32'd0);
      chk("bp so_hold",  32'(SO),  32'h1E);
    end
    ACK = 1'b1;
    @(posedge C); #1;
    ACK = 1'b0;
    chk("bp rdy_ack", 32'(RDY), 32'd1);
    chk("bp vld_ack", 32'(VLD), 32'd0);
    chk("bp so_kept", 32'(SO),  32'h1E);
    @(posedge C); #1;

    // Reset mid-SHIFT, three edges after the accept edge.
    DI = 8'hF0; SEL = 3'd6; LOAD = 1'b1; ACK = 1'b1;
    @(posedge C); #1;
    LOAD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge C); #1;
    end
    chk("midrst busy", 32'(RDY), 32'd0);
    CLR_N = 1'b0;
    #1;
    chk("midrst so",  32'(SO),  32'h00);
    chk("midrst vld", 32'(VLD), 32'd0);
    chk("midrst rdy", 32'(RDY), 32'd1);
    @(posedge C); #1;
    CLR_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge C); #1;
      chk("midrst no_vld", 32'(VLD), 32'd0);
    end

    // Reset while DONE is held.
    DI = 8'h66; SEL = 3'd0; LOAD = 1'b1; ACK = 1'b0;
    @(posedge C); #1;
    LOAD = 1'b0;
    chk("donerst vld", 32'(VLD), 32'd1);
    CLR_N = 1'b0;
    #1;
    chk("donerst vld_clr", 32'(VLD), 32'd0);
    chk("donerst so_clr",  32'(SO),  32'h00);
    @(posedge C); #1;
    CLR_N = 1'b1;
    @(posedge C); #1;

    run("postrst", 8'h81, 3'd4, 1'b0, 8'h08, 5);

`ifdef LRS_ARITH_EN
    run("arith1", 8'h90, 3'd3, 1'b1, 8'hF2, 4);
    run("arith0", 8'h90, 3'd3, 1'b0, 8'h12, 4);
    run("arith1pos", 8'h70, 3'd2, 1'b1, 8'h1C, 3);
`else
    run("logic90", 8'h90, 3'd3, 1'b0, 8'h12, 4);
`endif

    repeat (3) @(posedge C);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
